// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one multi-cycle SRAM controller between two word requesters.
// One transaction at a time: IDLE -> BUSY (until mem_ready) -> DONE (ready pulse) -> IDLE.
module sram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_W_EN,
    input  logic              p0_R_EN,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_data_in,
    output logic [DATA_W-1:0] p0_data_out,
    output logic              p0_ready,
    input  logic              p1_W_EN,
    input  logic              p1_R_EN,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_data_in,
    output logic [DATA_W-1:0] p1_data_out,
    output logic              p1_ready,
    output logic              mem_W_EN,
    output logic              mem_R_EN,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ready,
    output logic              grant,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Port handshake: a port holds W_EN/R_EN (plus address/data) until it sees its
    // one-cycle ready; ready always pulses once per granted transaction, even if the
    // request was dropped mid-access.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic              lat_we;
    logic              lat_re;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              last_win;
    logic              p0_req;
    logic              p1_req;
    logic              win;

    assign p0_req = p0_W_EN | p0_R_EN;
    assign p1_req = p1_W_EN | p1_R_EN;

    // On a tie the port that lost last time goes next.
    always_comb begin
        win = 1'b0;
        if (p0_req && p1_req) win = ~last_win;
        else                  win = p1_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_we      <= 1'b0;
            lat_re      <= 1'b0;
            lat_addr    <= '0;
            lat_data    <= '0;
            grant       <= 1'b0;
            last_win    <= 1'b1;
            p0_data_out <= '0;
            p1_data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        state    <= BUSY;
                        grant    <= win;
                        last_win <= win;
                        // Write takes precedence when both enables are set.
                        lat_we   <= win ? p1_W_EN : p0_W_EN;
                        lat_re   <= win ? (p1_R_EN & ~p1_W_EN) : (p0_R_EN & ~p0_W_EN);
                        lat_addr <= win ? p1_address : p0_address;
                        lat_data <= win ? p1_data_in : p0_data_in;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        state <= DONE;
                        if (lat_re) begin
                            if (grant) p1_data_out <= mem_data_out;
                            else       p0_data_out <= mem_data_out;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // DONE drops both enables so the controller sees an idle cycle after completion.
    assign mem_W_EN    = (state == BUSY) & lat_we;
    assign mem_R_EN    = (state == BUSY) & lat_re;
    assign mem_address = lat_addr;
    assign mem_data_in = lat_data;
    assign p0_ready    = (state == DONE) & ~grant;
    assign p1_ready    = (state == DONE) & grant;
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a six-cycle SRAM controller model.
// Cycle 0 is the cycle a request is first presented; checks sample #1 after each edge.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_W_EN, p0_R_EN, p1_W_EN, p1_R_EN;
    logic [31:0] p0_address, p1_address, p0_data_in, p1_data_in;
    logic [31:0] p0_data_out, p1_data_out;
    logic        p0_ready, p1_ready;
    logic        mem_W_EN, mem_R_EN;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_ready;
    logic        grant, busy;
    logic [1:0]  dbg_state;

    logic        model_rdy;
    logic        stray_rdy;
    logic [2:0]  model_cnt;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset
    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_W_EN(p0_W_EN), .p0_R_EN(p0_R_EN), .p0_address(p0_address),
        .p0_data_in(p0_data_in), .p0_data_out(p0_data_out), .p0_ready(p0_ready),
        .p1_W_EN(p1_W_EN), .p1_R_EN(p1_R_EN), .p1_address(p1_address),
        .p1_data_in(p1_data_in), .p1_data_out(p1_data_out), .p1_ready(p1_ready),
        .mem_W_EN(mem_W_EN), .mem_R_EN(mem_R_EN), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ready(mem_ready),
        .grant(grant), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- controller model: enables high cycles 1..6, mem_ready in cycle 6
    assign mem_ready    = model_rdy | stray_rdy;
    assign mem_data_out = (mem_address == 32'h10) ? 32'hDEAD_BEEF :
                          (mem_address == 32'h20) ? 32'hCAFE_F00D :
                          (mem_address ^ 32'hA5A5_5A5A);

    always @(posedge clk) begin
        if (rst) begin
            model_cnt <= 3'd0;
            model_rdy <= 1'b0;
        end else if (model_rdy) begin
            model_cnt <= 3'd0;
            model_rdy <= 1'b0;
        end else if (mem_W_EN || mem_R_EN) begin
            if (model_cnt == 3'd4) model_rdy <= 1'b1;
            model_cnt <= model_cnt + 3'd1;
        end
    end

    // ---------------- driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_W_EN = 0; p0_R_EN = 0; p1_W_EN = 0; p1_R_EN = 0;
        p0_address = '0; p1_address = '0; p0_data_in = '0; p1_data_in = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wen"},  mem_W_EN, 0);
        chk({tag, "_ren"},  mem_R_EN, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_din"},  mem_data_in, 0);
        chk({tag, "_rdy0"}, p0_ready, 0);
        chk({tag, "_rdy1"}, p1_ready, 0);
        chk({tag, "_do0"},  p0_data_out, 0);
        chk({tag, "_do1"},  p1_data_out, 0);
        chk({tag, "_gnt"},  grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_st"},   dbg_state, 0);
    endtask

    // ---------------- directed sequence
    initial begin
        stray_rdy = 1'b0;
        do_reset();
        chk_all_zero("reset");

        // Single read on port 0
        p0_R_EN = 1; p0_address = 32'h10;
        for (int c = 1; c <= 6; c++) begin
            step();
            chk($sformatf("t1_ren_c%0d", c), mem_R_EN, 1);
            chk($sformatf("t1_wen_c%0d", c), mem_W_EN, 0);
            chk($sformatf("t1_rdy_c%0d", c), p0_ready, 0);
            chk($sformatf("t1_addr_c%0d", c), mem_address, 32'h10);
        end
        step();
        chk("t1_rdy_c7", p0_ready, 1);
        chk("t1_ren_c7", mem_R_EN, 0);
        chk("t1_do0", p0_data_out, 32'hDEAD_BEEF);
        chk("t1_do1", p1_data_out, 0);
        chk("t1_gnt", grant, 0);
        p0_R_EN = 0;
        step();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_rdy", p0_ready, 0);

        // Port 1 write with R_EN also high: write wins
        p1_W_EN = 1; p1_R_EN = 1; p1_address = 32'h40; p1_data_in = 32'h1234_5678;
        for (int c = 1; c <= 6; c++) begin
            step();
            chk($sformatf("t2_wen_c%0d", c), mem_W_EN, 1);
            chk($sformatf("t2_ren_c%0d", c), mem_R_EN, 0);
            chk($sformatf("t2_din_c%0d", c), mem_data_in, 32'h1234_5678);
            chk($sformatf("t2_addr_c%0d", c), mem_address, 32'h40);
            chk($sformatf("t2_gnt_c%0d", c), grant, 1);
        end
        step();
        chk("t2_rdy1", p1_ready, 1);
        chk("t2_rdy0", p0_ready, 0);
        chk("t2_do1", p1_data_out, 0);
        chk("t2_do0", p0_data_out, 32'hDEAD_BEEF);
        idle_inputs();
        step();

        // Both ports request continuously from reset: grants alternate 0,1,0,1
        do_reset();
        chk("t3_rst_do0", p0_data_out, 0);
        p0_R_EN = 1; p0_address = 32'h10;
        p1_R_EN = 1; p1_address = 32'h20;
        for (int c = 1; c <= 32; c++) begin
            step();
            chk($sformatf("t3_rdy0_c%0d", c), p0_ready, (c == 7 || c == 23));
            chk($sformatf("t3_rdy1_c%0d", c), p1_ready, (c == 15 || c == 31));
            if (c == 15) chk("t3_do1", p1_data_out, 32'hCAFE_F00D);
            if (c == 7 || c == 23) chk($sformatf("t3_gnt_c%0d", c), grant, 0);
            if (c == 15 || c == 31) chk($sformatf("t3_gnt_c%0d", c), grant, 1);
        end
        idle_inputs();
        step();

        // Port 1 raises a read at cycle 3 while port 0 owns the controller
        do_reset();
        p0_R_EN = 1; p0_address = 32'h10;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c <= 8) chk($sformatf("t4_addr_c%0d", c), mem_address, 32'h10);
            chk($sformatf("t4_rdy0_c%0d", c), p0_ready, (c == 7));
            chk($sformatf("t4_rdy1_c%0d", c), p1_ready, (c == 15));
            if (c == 9) begin
                chk("t4_gnt_c9", grant, 1);
                chk("t4_addr_c9", mem_address, 32'h20);
            end
            if (c == 3) begin p1_R_EN = 1; p1_address = 32'h20; end
            if (c == 7) p0_R_EN = 0;
        end
        chk("t4_do1", p1_data_out, 32'hCAFE_F00D);
        idle_inputs();
        step();

        // Port 0 drops its request at cycle 3: no abort, no second transaction
        p0_R_EN = 1; p0_address = 32'h10;
        for (int c = 1; c <= 10; c++) begin
            step();
            chk($sformatf("t5_rdy_c%0d", c), p0_ready, (c == 7));
            chk($sformatf("t5_busy_c%0d", c), busy, (c <= 7));
            chk($sformatf("t5_ren_c%0d", c), mem_R_EN, (c <= 6));
            if (c == 3) p0_R_EN = 0;
        end

        // Reset at cycle 4 mid-read, then a port 1 read completes normally
        p0_R_EN = 1; p0_address = 32'h30;
        for (int c = 1; c <= 4; c++) step();
        chk("t6_busy_c4", busy, 1);
        rst = 1; p0_R_EN = 0;
        step();
        chk_all_zero("t6_rst");
        rst = 0;
        p1_R_EN = 1; p1_address = 32'h20;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk($sformatf("t6_rdy1_c%0d", c), p1_ready, (c == 7));
            chk($sformatf("t6_ren_c%0d", c), mem_R_EN, (c <= 6));
        end
        chk("t6_do1", p1_data_out, 32'hCAFE_F00D);
        chk("t6_gnt", grant, 1);
        idle_inputs();
        step();

        // Stray mem_ready in IDLE is ignored
        stray_rdy = 1;
        step();
        stray_rdy = 0;
        chk("t7_busy", busy, 0);
        chk("t7_st", dbg_state, 0);
        step();
        chk("t7_rdy0", p0_ready, 0);
        chk("t7_rdy1", p1_ready, 0);
        chk("t7_do1", p1_data_out, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
